// File: rtl/fetch_pc_queue_if.sv
// Fetch PC queue bus: control inputs from the branch/ALU logic and the
// valid/ready PC output toward decode.
// master = fetch unit side, slave = branch logic + decode side.
`timescale 1ns/1ps
interface fetch_pc_queue_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned QDEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

    logic              stall;
    logic              B;
    logic              bne;
    logic              Z;
    logic [ADDR_W-1:0] B_addr;
    logic              J;
    logic [ADDR_W-1:0] J_addr;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  count;
    logic              redirect;
    logic              misalign;

    modport master (
        input  stall, B, bne, Z, B_addr, J, J_addr, out_ready,
        output out_valid, addr, count, redirect, misalign
    );

    modport slave (
        output stall, B, bne, Z, B_addr, J, J_addr, out_ready,
        input  out_valid, addr, count, redirect, misalign
    );
endinterface

// File: rtl/fetch_pc_queue.sv
// Fetch PC generator with a small output FIFO.
// Produces sequential PCs, resolves BEQ/BNE on Z and unconditional jumps,
// and buffers fetched PCs so decode can back-pressure with valid/ready.
// Optional build macro FETCH_MISALIGN_TRAP_EN: a redirect to a target with
// nonzero low alignment bits is dropped and flagged on misalign instead of
// being silently aligned.
`timescale 1ns/1ps
module fetch_pc_queue #(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned       INSTR_BYTES = 4,
    parameter int unsigned       QDEPTH      = 4
) (
    input  logic             clock,
    input  logic             reset,
    fetch_pc_queue_if.master bus
);
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(INSTR_BYTES);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(QDEPTH);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mem [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              redirect_q;

    logic              br_taken;
    logic              redirect_req;
    logic [ADDR_W-1:0] target;
    logic              take;
    logic              valid;
    logic              full;
    logic              do_pop;
    logic              do_enq;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic              trap;
    logic              misalign_q;
`endif

    // Redirect resolution and FIFO push/pop decisions for this edge.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        br_taken     = bus.B & (bus.bne ? ~bus.Z : bus.Z);
        redirect_req = bus.J | br_taken;
        target       = bus.J ? bus.J_addr : bus.B_addr;
`ifdef FETCH_MISALIGN_TRAP_EN
        trap         = redirect_req & (|(target & LOW_MASK));
        take         = redirect_req & ~trap;
`else
        take         = redirect_req;
`endif
        valid  = (cnt != '0);
        full   = (cnt == FULL_CNT);
        // A flush discards the head, so it is never also popped.
        do_pop = valid & bus.out_ready & ~take;
        // A full FIFO still accepts a new PC when the head leaves this edge.
        do_enq = ~take & ~bus.stall & (~full | do_pop);
    end

    // PC, FIFO pointers/occupancy and the redirect pulse.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            redirect_q <= 1'b0;
        end else begin
            redirect_q <= take;
            if (take) begin
                pc     <= target & ~LOW_MASK;
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (do_enq) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    pc     <= pc + PC_INC;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                unique case ({do_enq, do_pop})
                    2'b10:   cnt <= cnt + CNT_W'(1);
                    2'b01:   cnt <= cnt - CNT_W'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    // FIFO storage write.
    // NOTE: storage has no reset; cnt gates everything read from it.
    always_ff @(posedge clock) begin
        if (do_enq) begin
            mem[wr_ptr] <= pc;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // One-cycle pulse flagging a dropped misaligned redirect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= trap;
        end
    end
    assign bus.misalign = misalign_q;
`else
    assign bus.misalign = 1'b0;
`endif

    assign bus.out_valid = valid;
    assign bus.addr      = valid ? mem[rd_ptr] : '0;
    assign bus.count     = cnt;
    assign bus.redirect  = redirect_q;

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Bench for fetch_pc_queue: directed phases push the PCs decode should
// receive into a scoreboard; a negedge monitor compares every accepted head.
`timescale 1ns/1ps
module tb_fetch_pc_queue;
    logic clock;
    logic reset;

    fetch_pc_queue_if #(.ADDR_W(32), .QDEPTH(4)) bus ();

    fetch_pc_queue #(
        .ADDR_W     (32),
        .RESET_PC   (32'h0000_0000),
        .INSTR_BYTES(4),
        .QDEPTH     (4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int          n_acc    = 0;
    int          acc0     = 0;
    logic [31:0] exp_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(i * 4));
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every head accepted by decode must match the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_unexpected: got 0x%08h expected nothing", bus.addr);
                end else begin
                    check("pop_addr", bus.addr, exp_q.pop_front());
                end
                n_acc++;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        bus.stall  = 1'b0;
        bus.B      = 1'b0;
        bus.bne    = 1'b0;
        bus.Z      = 1'b0;
        bus.B_addr = '0;
        bus.J      = 1'b0;
        bus.J_addr = '0;
        bus.out_ready = 1'b1;
        repeat (2) tick();

        // Reset state
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_addr", bus.addr, 32'd0);
        check("rst_redirect", 32'(bus.redirect), 32'd0);
        check("rst_misalign", 32'(bus.misalign), 32'd0);

        // Sequential fetch with decode always ready: 0,4,8,C
        push_seq(32'h0, 16);
        reset = 1'b1;
        acc0  = n_acc;
        tick();
        check("seq_first_head", bus.addr, 32'h0);
        check("seq_count", 32'(bus.count), 32'd1);
        repeat (3) begin
            tick();
            check("seq_count", 32'(bus.count), 32'd1);
        end
        #6;
        check("seq_accepts", 32'(n_acc - acc0), 32'd4);

        // Mid-stream reset drops everything immediately
        reset = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_count", 32'(bus.count), 32'd0);
        check("midrst_addr", bus.addr, 32'd0);
        exp_q.delete();
        tick();

        // Back-pressure: fill to 4, then drain in order from RESET_PC
        bus.out_ready = 1'b0;
        push_seq(32'h0, 16);
        reset = 1'b1;
        acc0  = n_acc;
        repeat (6) tick();
        check("full_count", 32'(bus.count), 32'd4);
        check("full_head", bus.addr, 32'h0);
        check("full_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        check("full_pop_enq_count", 32'(bus.count), 32'd4);
        repeat (4) tick();
        bus.out_ready = 1'b0;
        check("drain_accepts", 32'(n_acc - acc0), 32'd5);

        // BEQ taken (Z=1) while full: flush, redirect, restart at 0x18
        exp_q.delete();
        acc0 = n_acc;
        bus.B = 1'b1; bus.bne = 1'b0; bus.Z = 1'b1; bus.B_addr = 32'h18;
        tick();
        bus.B = 1'b0; bus.Z = 1'b0;
        check("beq_redirect", 32'(bus.redirect), 32'd1);
        check("beq_flush_count", 32'(bus.count), 32'd0);
        check("beq_flush_valid", 32'(bus.out_valid), 32'd0);
        push_seq(32'h18, 16);
        bus.out_ready = 1'b1;
        tick();
        check("beq_redirect_pulse_end", 32'(bus.redirect), 32'd0);
        check("beq_target_head", bus.addr, 32'h18);
        check("beq_target_count", 32'(bus.count), 32'd1);
        repeat (3) tick();

        // BEQ with Z=0: not taken, stream continues
        bus.B = 1'b1; bus.bne = 1'b0; bus.Z = 1'b0; bus.B_addr = 32'h80;
        tick();
        bus.B = 1'b0;
        check("beq_nt_redirect", 32'(bus.redirect), 32'd0);
        tick();

        // BNE taken (Z=0) to 0x84
        bus.B = 1'b1; bus.bne = 1'b1; bus.Z = 1'b0; bus.B_addr = 32'h84;
        bus.out_ready = 1'b0;
        check("branch_accepts", 32'(n_acc - acc0), 32'd5);
        tick();
        bus.B = 1'b0; bus.bne = 1'b0;
        check("bne_redirect", 32'(bus.redirect), 32'd1);
        check("bne_flush_count", 32'(bus.count), 32'd0);
        exp_q.delete();
        push_seq(32'h84, 16);
        bus.out_ready = 1'b1;
        acc0 = n_acc;
        tick();
        check("bne_target_head", bus.addr, 32'h84);
        repeat (2) tick();
        bus.out_ready = 1'b0;
        check("bne_accepts", 32'(n_acc - acc0), 32'd2);

        // Fill, then J and taken B together while full and stalled: J wins
        repeat (4) tick();
        check("refill_count", 32'(bus.count), 32'd4);
        check("refill_head", bus.addr, 32'h8C);
        exp_q.delete();
        bus.stall = 1'b1;
        bus.J = 1'b1; bus.J_addr = 32'h20;
        bus.B = 1'b1; bus.bne = 1'b0; bus.Z = 1'b1; bus.B_addr = 32'h40;
        tick();
        bus.J = 1'b0; bus.B = 1'b0; bus.Z = 1'b0;
        check("jb_redirect", 32'(bus.redirect), 32'd1);
        check("jb_flush_count", 32'(bus.count), 32'd0);
        check("jb_flush_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("stall_no_enq_count", 32'(bus.count), 32'd0);
        bus.stall = 1'b0;
        push_seq(32'h20, 16);
        bus.out_ready = 1'b1;
        acc0 = n_acc;
        tick();
        check("jump_target_head", bus.addr, 32'h20);
        check("jump_target_count", 32'(bus.count), 32'd1);
        bus.stall = 1'b1;
        tick();
        check("stall_pop_count", 32'(bus.count), 32'd0);
        bus.stall = 1'b0;
        tick();
        check("stall_resume_head", bus.addr, 32'h24);
        tick();
        bus.out_ready = 1'b0;
        check("stall_accepts", 32'(n_acc - acc0), 32'd2);

        // Wrap: jump near the top of the address space
        exp_q.delete();
        bus.J = 1'b1; bus.J_addr = 32'hFFFF_FFF8;
        tick();
        bus.J = 1'b0;
        check("wrap_redirect", 32'(bus.redirect), 32'd1);
        push_seq(32'hFFFF_FFF8, 16);
        bus.out_ready = 1'b1;
        acc0 = n_acc;
        repeat (4) tick();
        bus.out_ready = 1'b0;
        check("wrap_accepts", 32'(n_acc - acc0), 32'd3);

        // Misaligned branch target 0x1E
        bus.B = 1'b1; bus.bne = 1'b0; bus.Z = 1'b1; bus.B_addr = 32'h1E;
        tick();
        bus.B = 1'b0; bus.Z = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_redirect", 32'(bus.redirect), 32'd0);
        check("mis_pulse", 32'(bus.misalign), 32'd1);
        check("mis_count", 32'(bus.count), 32'd2);
        check("mis_head", bus.addr, 32'h4);
`else
        check("mis_redirect", 32'(bus.redirect), 32'd1);
        check("mis_pulse", 32'(bus.misalign), 32'd0);
        check("mis_count", 32'(bus.count), 32'd0);
        exp_q.delete();
        push_seq(32'h1C, 8);
`endif
        bus.out_ready = 1'b1;
        acc0 = n_acc;
        tick();
        check("mis_pulse_end", 32'(bus.misalign), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_seq_head", bus.addr, 32'h8);
`else
        check("mis_aligned_head", bus.addr, 32'h1C);
`endif
        repeat (2) tick();
        bus.out_ready = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_accepts", 32'(n_acc - acc0), 32'd3);
`else
        check("mis_accepts", 32'(n_acc - acc0), 32'd2);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_pc_queue.md
Name: fetch_pc_queue

Overview:
- Parametrised successor to the single-register Fetch PC unit.
- Generates sequential instruction addresses and resolves conditional branches (BEQ/BNE on the Z flag) and unconditional jumps.
- Buffers fetched PCs in a small FIFO so downstream decode can back-pressure with a valid/ready handshake.
- Sits between the branch/ALU flag logic and the instruction-memory/decode stage.

Parameters:
- ADDR_W, 32, PC and target width in bits.
- RESET_PC, 32'h00000000, PC value loaded on reset.
- INSTR_BYTES, 4, sequential PC increment; a power of two, ≥1.
- QDEPTH, 4, FIFO depth in entries; a power of two, ≥2.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  freeze PC generation; no enqueue.
- B  in  1  conditional branch request this cycle.
- bne  in  1  branch sense: 0 = taken when Z=1 (BEQ), 1 = taken when Z=0 (BNE).
- Z  in  1  ALU zero flag.
- B_addr  in  ADDR_W  branch target.
- J  in  1  unconditional jump request.
- J_addr  in  ADDR_W  jump target.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- addr  out  ADDR_W  PC at the FIFO head.
- count  out  $clog2(QDEPTH)+1  current FIFO occupancy.
- redirect  out  1  registered pulse, 1 cycle after any taken branch or jump.
- misalign  out  1  registered pulse for a misaligned target (feature only).

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC, FIFO empty.
  - out_valid=0, addr=0, count=0, redirect=0, misalign=0.
- Taken branch: br_taken = B & (bne ? ~Z : Z).
- Per-edge priority, highest first:
  - J → pc←J_addr, FIFO flushed (count←0), no enqueue/pop this edge, redirect←1.
  - br_taken → same as J using B_addr.
  - stall → pc holds, no enqueue; pop still allowed.
  - Otherwise:
    - enqueue pc when FIFO not full, then pc←pc+INSTR_BYTES.
    - when full, pc holds.
- Pop: occurs when out_valid & out_ready, unless flushed on the same edge.
- Full FIFO with simultaneous pop and enqueue: both occur, count unchanged.
- Pop from empty: impossible, since out_valid=0.
- J and B asserted together: J wins and B_addr is ignored.
- Redirect while full or stalled: flush and retarget still happen; a redirect overrides stall.
- Latency:
  - A target loaded at edge N is enqueued at edge N+1, so out_valid=1 and addr=target after N+1.
  - The first PC after reset deasserts appears one edge after the first active edge.
- Arithmetic:
  - PC wraps modulo 2^ADDR_W; for example, {ADDR_W{1}}-3+4 → 0 with no flag.
- Alignment: the low log2(INSTR_BYTES) bits of a jump/branch target are forced to 0 before loading.
- addr, out_valid and count are derived from registered state only; no combinational path from B, J or Z.
- Reset asserted mid-operation clears everything immediately. The next fetch restarts from RESET_PC.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect whose target has nonzero low alignment bits is not taken.
  - pc and FIFO are unchanged, redirect stays 0, and misalign pulses 1 cycle later.
  - Normal sequential fetch continues.
- Undefined:
  - Low bits are masked silently, as above.
  - misalign is tied to 0.

Test Plan:
- Reset low, then release with stall=0, out_ready=1, B=J=0 → addr sequence 0x00, 0x04, 0x08, 0x0C on consecutive cycles; count stays ≤1.
- out_ready=0 for 6 cycles → count rises to 4 and holds. pc stops at 0x10 and addr stays 0x00. Then out_ready=1 → addr 0x00, 0x04, 0x08, 0x0C, 0x10, with no PC skipped or duplicated.
- Branch sense:
  - B=1, bne=0, Z=1, B_addr=0x18 → FIFO flushed, redirect pulse, next addr=0x18, then 0x1C.
  - Same with Z=0 → no redirect; sequence continues.
  - bne=1, Z=0, B_addr=0x84 → next addr=0x84.
- J=1 with J_addr=0x20 and B=1, Z=1, B_addr=0x40 on the same edge while FIFO full and stall=1 → redirect to 0x20; count=0; next addr=0x20.
- Wrap and reset:
  - pc near 0xFFFFFFF8 → addr 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
  - Assert reset mid-stream → out_valid drops immediately and restarts at RESET_PC.
- B_addr=0x1E:
  - Feature off → next addr=0x1C.
  - FETCH_MISALIGN_TRAP_EN defined → misalign pulse, no redirect, sequence continues.
